// File: rtl/bram_stream_reader_if.sv
// Bus bundle for bram_stream_reader: burst command, RAM read port and output stream.
// The master modport is the reader itself; slave is whatever surrounds it.
interface bram_stream_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  re;
  logic [DATA_WIDTH-1:0] do_data;
  logic                  do_valid;

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, do_data, do_valid, out_ready,
    output cmd_ready, rd_addr, re, out_data, out_valid, out_last, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, do_data, do_valid, out_ready,
    input  cmd_ready, rd_addr, re, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Burst read sequencer for a one-cycle block RAM: issues reads only when the
// 2-entry output buffer can absorb them, and streams words out with a LAST tag.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  bram_stream_reader_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_live;

  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [1:0]            r_buf_last;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic w_pop, w_push, w_issue_ok, w_re, w_cmd_ready, w_accept, w_final_re;

  assign w_pop  = (r_count != 2'd0) && bus.out_ready;
  // Only data answering our own read is captured; this also drops a stray
  // DO_VALID right after reset, since the in-flight flag starts cleared.
  assign w_push = bus.do_valid && r_inflight;

  // Buffered + in-flight words, less the word leaving this cycle, must stay below 2.
  assign w_issue_ok = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign w_final_re = w_re && (r_remaining == LEN_WIDTH'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    w_next_state = r_state;
    w_re         = 1'b0;
    w_cmd_ready  = 1'b0;
    w_accept     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready = r_live;
        if (bus.cmd_valid && r_live && (bus.cmd_len != '0)) begin
          w_accept     = 1'b1;
          w_next_state = S_READ;
        end
      end
      S_READ: begin
        w_re = (r_remaining != '0) && w_issue_ok;
        if (w_final_re) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && r_buf_last[r_rd_ptr]) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Burst address/count and the one-cycle in-flight tracker.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_live          <= 1'b0;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_live          <= 1'b1;
      r_inflight      <= w_re;
      r_inflight_last <= w_final_re;
      if (w_accept) begin
        r_addr      <= bus.cmd_addr;
        r_remaining <= bus.cmd_len;
      end else if (w_re) begin
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
    end
  end

  // Two-entry FIFO between the RAM and the stream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: this storage is reset (only two words) so OUT_DATA reads 0 while in reset.
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last    <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= bus.do_data;
        r_buf_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.re        = w_re;
  assign bus.rd_addr   = r_addr;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_data  = r_buf_data[r_rd_ptr];
  assign bus.out_last  = r_buf_last[r_rd_ptr];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a one-cycle RAM model, a queue-based model of the
// expected address and word sequence, and directed plus randomized bursts.
module tb_bram_stream_reader;
  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bif ();

  bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bif)
  );

  // One-cycle RAM model, plus a hook to inject a stray DO_VALID.
  logic [DW-1:0] mem [DEPTH];
  logic          ram_dv   = 1'b0;
  logic          dv_force = 1'b0;
  logic [DW-1:0] ram_do   = '0;
  always @(posedge clk) begin
    ram_dv <= bif.re;
    ram_do <= mem[bif.rd_addr];
  end
  assign bif.do_valid = ram_dv | dv_force;
  assign bif.do_data  = ram_do;

  int            n_checks = 0;
  int            n_errors = 0;
  word_t         exp_q [$];
  logic [AW-1:0] addr_q [$];
  int            outstanding = 0;
  int            popped      = 0;
  int            re_seen     = 0;
  logic          prev_stall  = 1'b0;
  logic [DW-1:0] prev_data   = '0;
  logic          prev_last   = 1'b0;
  word_t         mon_w;
  logic          mon_pop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour of a burst: consecutive wrapped addresses, LAST on the final word.
  task automatic push_burst(input int addr, input int len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (addr + i) % DEPTH;
      addr_q.push_back(a[AW-1:0]);
      exp_q.push_back('{data: mem[a], last: (i == len - 1)});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_pop = bif.out_valid && bif.out_ready;
      if (bif.re) begin
        re_seen++;
        check("re_expected", 64'(addr_q.size() != 0), 64'd1);
        if (addr_q.size() != 0) check("rd_addr", 64'(bif.rd_addr), 64'(addr_q.pop_front()));
      end
      if (prev_stall) begin
        check("hold_valid", 64'(bif.out_valid), 64'd1);
        check("hold_data", 64'(bif.out_data), 64'(prev_data));
        check("hold_last", 64'(bif.out_last), 64'(prev_last));
      end
      if (mon_pop) begin
        popped++;
        check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_w = exp_q.pop_front();
          check("out_data", 64'(bif.out_data), 64'(mon_w.data));
          check("out_last", 64'(bif.out_last), 64'(mon_w.last));
        end
      end
      outstanding = outstanding + int'(bif.re) - int'(mon_pop);
      check("outstanding_le2", 64'(outstanding <= 2), 64'd1);
      prev_stall = bif.out_valid && !bif.out_ready;
      prev_data  = bif.out_data;
      prev_last  = bif.out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at posedge+1 of the cycle following the accepting edge.
  task automatic send_cmd(input int addr, input int len);
    int   waited = 0;
    logic took   = 1'b0;
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = addr[AW-1:0];
    bif.cmd_len   = len[LW-1:0];
    while (!took && waited < 50) begin
      @(negedge clk);
      if (bif.cmd_ready) begin
        took = 1'b1;
        push_burst(addr, len);
      end
      tick();
      waited++;
    end
    bif.cmd_valid = 1'b0;
    check("cmd_accepted", 64'(took), 64'd1);
  endtask

  // mode 0: ready held high, 1: toggles 1,0,1,0..., 2: random.
  task automatic run_until_idle(input int mode, input int budget);
    int   n    = 0;
    logic done = 1'b0;
    while (!done && n < budget) begin
      case (mode)
        0:       bif.out_ready = 1'b1;
        1:       bif.out_ready = (n % 2 == 0);
        default: bif.out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (exp_q.size() == 0 && addr_q.size() == 0 && !bif.busy) begin
        done = 1'b1;
        check("idle_cmd_ready", 64'(bif.cmd_ready), 64'd1);
      end
      tick();
      n++;
    end
    check("drain_done", 64'(done), 64'd1);
    bif.out_ready = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_re"},        64'(bif.re), 64'd0);
    check({tag, "_rd_addr"},   64'(bif.rd_addr), 64'd0);
    check({tag, "_out_valid"}, 64'(bif.out_valid), 64'd0);
    check({tag, "_out_data"},  64'(bif.out_data), 64'd0);
    check({tag, "_out_last"},  64'(bif.out_last), 64'd0);
    check({tag, "_busy"},      64'(bif.busy), 64'd0);
    check({tag, "_cmd_ready"}, 64'(bif.cmd_ready), 64'd0);
  endtask

  initial begin
    int r0, p0, n;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    bif.cmd_valid = 1'b0;
    bif.cmd_addr  = '0;
    bif.cmd_len   = '0;
    bif.out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    check("post_reset_cmd_ready", 64'(bif.cmd_ready), 64'd1);

    // Basic 4-word burst with cycle-exact latency
    bif.out_ready = 1'b1;
    send_cmd(5, 4);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("t1_re_%0d", k), 64'(bif.re), 64'(k < 4));
      check($sformatf("t1_valid_%0d", k), 64'(bif.out_valid), 64'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        check($sformatf("t1_data_%0d", k), 64'(bif.out_data), 64'(mem[5 + k - 2]));
        check($sformatf("t1_last_%0d", k), 64'(bif.out_last), 64'(k == 5));
      end
      check($sformatf("t1_busy_%0d", k), 64'(bif.busy), 64'(k <= 5));
      tick();
    end
    check("t1_cmd_ready_after", 64'(bif.cmd_ready), 64'd1);

    // Address wrap
    send_cmd(510, 4);
    run_until_idle(0, 40);

    // Backpressure stall
    bif.out_ready = 1'b0;
    r0 = re_seen;
    send_cmd(64, 8);
    repeat (10) tick();
    check("t3_re_before_stall", 64'(re_seen - r0), 64'd2);
    check("t3_valid_stalled", 64'(bif.out_valid), 64'd1);
    check("t3_head_data", 64'(bif.out_data), 64'(mem[64]));
    run_until_idle(0, 60);

    // Zero-length command
    r0 = re_seen;
    send_cmd(100, 0);
    repeat (5) begin
      @(negedge clk);
      check("t4_valid", 64'(bif.out_valid), 64'd0);
      check("t4_busy", 64'(bif.busy), 64'd0);
      check("t4_cmd_ready", 64'(bif.cmd_ready), 64'd1);
      tick();
    end
    check("t4_no_re", 64'(re_seen - r0), 64'd0);

    // Toggling ready
    send_cmd(200, 6);
    run_until_idle(1, 60);

    // Asynchronous reset mid-burst
    p0 = popped;
    send_cmd(300, 6);
    n = 0;
    while (popped - p0 < 2 && n < 20) begin
      tick();
      n++;
    end
    check("t6_two_popped", 64'(popped - p0 >= 2), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    exp_q.delete();
    addr_q.delete();
    outstanding = 0;
    prev_stall  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    dv_force = 1'b1;
    tick();
    dv_force = 1'b0;
    check("t6_cmd_ready", 64'(bif.cmd_ready), 64'd1);
    check("t6_no_stale_valid", 64'(bif.out_valid), 64'd0);
    tick();
    check("t6_stray_dv_ignored", 64'(bif.out_valid), 64'd0);
    send_cmd(50, 3);
    run_until_idle(0, 40);

    // Randomized bursts under random backpressure
    repeat (8) begin
      send_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 12)));
      run_until_idle(2, 200);
    end

    // Full-RAM burst wraps back to its start address
    send_cmd(17, DEPTH);
    run_until_idle(0, DEPTH + 50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side sequencer placed directly in front of the one-cycle block RAM.
- Accepts a burst command (start address, word count) and drives the RAM's RD_ADDR/RE.
- Captures DO on DO_VALID into a 2-entry output buffer and presents the words as a ready/valid stream with a LAST marker.
- Never issues a read it cannot buffer, so the RAM needs no stall input.

Parameters:
DATA_WIDTH  32  RAM word width; width of DO and OUT_DATA
ADDR_WIDTH  9  RAM address width; RAM depth is 2**ADDR_WIDTH
LEN_WIDTH  ADDR_WIDTH+1  burst length width; allows a full-RAM burst

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
CMD_VALID  in  1  command offered
CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY
CMD_ADDR  in  ADDR_WIDTH  first word address
CMD_LEN  in  LEN_WIDTH  number of words to read; 0 is legal
RD_ADDR  out  ADDR_WIDTH  RAM read address
RE  out  1  RAM read enable
DO  in  DATA_WIDTH  RAM read data
DO_VALID  in  1  RAM read-data valid; one cycle after RE
OUT_DATA  out  DATA_WIDTH  stream data
OUT_VALID  out  1  stream valid
OUT_READY  in  1  stream ready
OUT_LAST  out  1  marks the final word of a burst
BUSY  out  1  high from command accept until the last word is popped

Behaviour:
- Reset (RST_N low, asynchronous):
  - State goes to IDLE; buffer emptied; in-flight flag cleared.
  - All outputs go to 0 except CMD_READY, which is 0 during reset and goes to 1 in IDLE after release.
  - Reset mid-burst discards buffered words and the remaining count. Any DO_VALID in the first cycle after release is ignored.
- States:
  - IDLE: CMD_READY=1, BUSY=0.
    - Accept with CMD_LEN>0: latch addr and remaining count; go to READ.
    - Accept with CMD_LEN=0: stay in IDLE; no RE, no output word.
  - READ: CMD_READY=0, BUSY=1.
    - Issue rule: RE=1 when remaining>0 and (occupancy + inflight − pop) < 2.
      - occupancy: 0..2 words held in the buffer.
      - inflight: RE was asserted in the previous cycle.
      - pop: OUT_VALID && OUT_READY this cycle.
    - RD_ADDR = current address. On each RE, address increments modulo 2**ADDR_WIDTH (wraps from max to 0) and remaining decrements.
    - When the final RE is issued, go to DRAIN.
  - DRAIN: RE=0, BUSY=1.
    - Go to IDLE on the cycle the LAST word is popped. CMD_READY rises the following cycle.
- Capture:
  - On DO_VALID, DO is written into the buffer, tagged LAST if it was the final read of the burst.
  - The buffer never overflows by construction. DO_VALID arriving with the buffer full is a protocol violation and is not required to be handled.
- Output:
  - OUT_VALID = occupancy>0. OUT_DATA/OUT_LAST come from the buffer head.
  - Stream rule: once OUT_VALID is asserted, OUT_DATA and OUT_LAST hold until popped.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Latency:
  - Command accepted at edge E0; first RE in cycle E0+1.
  - DO_VALID in E0+2; OUT_VALID in E0+3.
- Throughput: with OUT_READY held high, one word per cycle sustained with no bubbles after the first.
- Backpressure: OUT_READY low stops RE issue after at most 2 words are buffered or in flight. Issue resumes in the same cycle OUT_READY rises (pop is counted in the issue rule).
- Length arithmetic: remaining is LEN_WIDTH wide. CMD_LEN=2**ADDR_WIDTH reads every word once, starting and ending the wrap at CMD_ADDR.

Test Plan:
1. Reset; CMD_ADDR=5, CMD_LEN=4, OUT_READY=1 -> RE in 4 consecutive cycles at RD_ADDR 5,6,7,8. OUT_DATA = mem[5..8] on 4 consecutive cycles starting 3 cycles after accept; OUT_LAST only on mem[8]; BUSY falls after it; CMD_READY=1 next cycle.
2. CMD_ADDR=510, CMD_LEN=4, ADDR_WIDTH=9 -> RD_ADDR 510,511,0,1; data order matches.
3. CMD_LEN=8 with OUT_READY=0 for 10 cycles, then 1 -> exactly 2 RE pulses before stall, OUT_VALID held with mem[addr] stable. After release, all 8 words arrive in order with no loss or duplication and LAST on the 8th.
4. CMD_LEN=0 -> no RE, no OUT_VALID, BUSY stays 0, CMD_READY stays 1.
5. OUT_READY toggling 1,0,1,0 on a 6-word burst -> occupancy never exceeds 2, never more than 2 words buffered or in flight, exact in-order data, single LAST.
6. RST_N pulsed low mid-burst, 2 words into a 6-word burst -> outputs 0 immediately (async); after release CMD_READY=1, no stale OUT_VALID. A new 3-word command completes correctly.
